// File: rtl/bn_param_mem_loader_if.sv
// Parameter stream (valid/ready) and BN MEM write-port bundle for bn_param_mem_loader.
// slave = loader side, master = host/DMA + memory side.
interface bn_param_mem_loader_if #(
  parameter int ADDR_W = 16
);
  logic [31:0]       s_axis_data;
  logic              s_axis_valid;
  logic              s_axis_last;
  logic              s_axis_ready;
  logic              bn_mem_wen_a;
  logic [ADDR_W-1:0] bn_mem_addr_a;
  logic [63:0]       bn_mem_din_a;

  modport master (
    output s_axis_data, s_axis_valid, s_axis_last,
    input  s_axis_ready, bn_mem_wen_a, bn_mem_addr_a, bn_mem_din_a
  );

  modport slave (
    input  s_axis_data, s_axis_valid, s_axis_last,
    output s_axis_ready, bn_mem_wen_a, bn_mem_addr_a, bn_mem_din_a
  );
endinterface

// File: rtl/bn_param_mem_loader.sv
// Loads BN A/B parameter pairs from a 32-bit stream into the 64-bit BN MEM write port.
// Optional stream-framing check on s_axis_last is enabled with macro BN_LOADER_LAST_CHK_EN.
module bn_param_mem_loader #(
  parameter int ADDR_W    = 16,
  parameter int SIM_DELAY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   param_n,
  output logic                busy,
  output logic                done,
  output logic                en_bn_act_proc,
  output logic                err_last,
  bn_param_mem_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RECV_A, RECV_B, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pairCnt_q, pairCnt_d;
  logic [ADDR_W-1:0] paramN_q, paramN_d;
  logic [31:0]       aWord_q, aWord_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       din_q, din_d;
  logic              en_q, en_d;
  logic              err_q, err_d;
  logic              ready;
  logic              handshake;
  logic              lastErr;

  assign ready     = (state_q == RECV_A) || (state_q == RECV_B);
  assign handshake = ready && bus.s_axis_valid;

`ifdef BN_LOADER_LAST_CHK_EN
  // last must appear exactly on the final B word of the load
  assign lastErr = handshake &&
                   (bus.s_axis_last != ((state_q == RECV_B) && (pairCnt_q == paramN_q)));
`else
  assign lastErr = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pairCnt_q <= '0;
      paramN_q  <= '0;
      aWord_q   <= '0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pairCnt_q <= pairCnt_d;
      paramN_q  <= paramN_d;
      aWord_q   <= aWord_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      en_q      <= en_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pairCnt_d = pairCnt_q;
    paramN_d  = paramN_q;
    aWord_d   = aWord_q;
    wen_d     = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    en_d      = en_q;
    err_d     = err_q || lastErr;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          paramN_d  = param_n;
          pairCnt_d = '0;
          en_d      = 1'b0;
          err_d     = 1'b0;
          state_d   = RECV_A;
        end
      end
      RECV_A: begin
        if (handshake) begin
          aWord_d = bus.s_axis_data;
          state_d = RECV_B;
        end
      end
      RECV_B: begin
        if (handshake) begin
          wen_d  = 1'b1;
          addr_d = pairCnt_q;
          din_d  = {bus.s_axis_data, aWord_q};
          // compare before increment so param_n = all-ones never wraps the counter
          if (pairCnt_q == paramN_q) begin
            state_d = DONE;
          end else begin
            pairCnt_d = pairCnt_q + 1'b1;
            state_d   = RECV_A;
          end
        end
      end
      DONE: begin
        en_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy              = ready;
  assign done              = (state_q == DONE);
  assign en_bn_act_proc    = en_q;
  assign err_last          = err_q;
  assign bus.s_axis_ready  = ready;
  assign bus.bn_mem_wen_a  = wen_q;
  assign bus.bn_mem_addr_a = addr_q;
  assign bus.bn_mem_din_a  = din_q;

endmodule
